rl_ram_fifo: RTL and testbench
==============================

RL_RAM_FIFO -- requirements
Module: rl_ram_fifo

Interface
REQ-001 SHALL have parameter ABITS, default 4: log2 of storage depth; DEPTH = 2**ABITS words.
REQ-002 SHALL have parameter DBITS, default 32: data word width.
REQ-003 SHALL have parameter TECHNOLOGY, default "GENERIC": passed unchanged to the RAM instance.
REQ-004 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port valid_i  input  1  write side: d_i holds a word to push.
REQ-007 SHALL have port d_i  input  DBITS  write data.
REQ-008 SHALL have port ready_o  output  1  write side: word accepted on a clock edge where valid_i && ready_o.
REQ-009 SHALL have port valid_o  output  1  read side: q_o holds the head word.
REQ-010 SHALL have port q_o  output  DBITS  head data, first-word-fall-through.
REQ-011 SHALL have port ready_i  input  1  read side: head consumed on a clock edge where valid_o && ready_i.

Function
REQ-012 SHALL hold at most DEPTH words total, counting RAM entries, any in-flight RAM read and the output register.
REQ-013 SHALL drive ready_o = (count < DEPTH), registered, independent of ready_i; no push-through when full.
REQ-014 SHALL drive valid_o = 1 only when q_o is the oldest unconsumed word; q_o and valid_o SHALL not change while valid_o && !ready_i.
REQ-015 SHALL present a word pushed into an empty FIFO on q_o with valid_o=1 the cycle after acceptance, bypassing the RAM.
REQ-016 SHALL write the RAM at a wrapping ABITS-bit write pointer and read it at a wrapping ABITS-bit read pointer; the read latency is 1 cycle.
REQ-017 SHALL never issue a RAM read to the address being written in the same cycle; such words take the bypass path.
REQ-018 SHALL sustain one push and one pop per cycle indefinitely when 2 <= count < DEPTH.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and preserve strict FIFO order.
REQ-020 SHALL ignore valid_i when ready_o=0 and ignore ready_i when valid_o=0; neither case changes state.
REQ-021 SHALL drive q_o with a don't-care value when valid_o=0; the bench SHALL NOT check it.

Reset
REQ-022 SHALL, while rst_i=1 at a clock edge, clear the pointers, count, in-flight flag and output-register valid; on the next cycle ready_o=1 and valid_o=0.
REQ-023 SHALL discard all stored and in-flight words on reset mid-operation; RAM contents SHALL not be reset.
REQ-024 SHALL drive the RAM instance rst_ni from ~rst_i.

Configuration
REQ-025 SHALL, when RL_RAM_FIFO_LEVEL_EN is defined, add port count_o, output, ABITS+1 bits, registered occupancy 0..DEPTH, reset to 0.
REQ-026 SHALL, when RL_RAM_FIFO_LEVEL_EN is undefined, omit count_o; all other behaviour is identical.

Structure
REQ-027 SHALL place the head-stage state enum (EMPTY, LOADING, VALID) and no other types in package rl_ram_fifo_pkg.
REQ-028 SHALL instantiate exactly one rl_ram_1r1w with ABITS, DBITS and TECHNOLOGY passed through, be_i tied to all ones, and re_i asserted only on issued reads.
REQ-029 SHALL contain no other sub-modules; the pointers, counter and head stage stay in rl_ram_fifo.

Verification (ABITS=2, DBITS=8, DEPTH=4)
REQ-030 SHALL cover: after reset, push 0xA5 with ready_i=0 -> valid_o=1, q_o=0xA5 the next cycle, held stable for 5 cycles.
REQ-031 SHALL cover: push 0x01..0x04 with ready_i=0 -> ready_o=0 after the 4th push; a 5th push of 0x05 is dropped; pops then return 01,02,03,04 and valid_o drops.
REQ-032 SHALL cover: continuous valid_i and ready_i for 20 cycles with incrementing data from 0x10 -> output sequence 0x10.. in order, with no gaps after the first word.
REQ-033 SHALL cover: at count=1, push and pop in the same cycle -> count stays 1 and the new word appears next.
REQ-034 SHALL cover: 3 words stored, rst_i pulsed for 1 cycle -> valid_o=0 and ready_o=1 next cycle; a later push of 0x77 pops as 0x77 with no stale data.
REQ-035 SHALL cover, with RL_RAM_FIFO_LEVEL_EN defined: random push/pop for 1000 cycles -> count_o matches the reference model every cycle.

Source files
------------

// File: rtl/rl_ram_fifo_pkg.sv
// Shared types for the rl_ram_fifo slice.
// Head-stage state of the FIFO output.
package rl_ram_fifo_pkg;

    // EMPTY:   no head word, FIFO holds nothing.
    // LOADING: head word is the RAM read data (read issued on the previous edge).
    // VALID:   head word is held in the local output register (bypass path).
    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        VALID
    } head_state_e;

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one synchronous write port with bit-write enables,
// one synchronous read port with 1-cycle latency. Read data holds until the
// next read enable. TECHNOLOGY selects the implementation; only the generic
// inferred array is provided here.
module rl_ram_1r1w #(
    parameter int unsigned ABITS      = 4,
    parameter int unsigned DBITS      = 32,
    parameter              TECHNOLOGY = "GENERIC"
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] be_i,
    input  logic [DBITS-1:0] d_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] q_o
);

    logic [DBITS-1:0] mem_q [2**ABITS];

    // Write port: only bits with be_i set are updated; contents never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~be_i) | (d_i & be_i);
        end
    end

    if (TECHNOLOGY == "GENERIC") begin : g_generic
        // Read port: registered data, updated only on a read enable.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                q_o <= '0;
            end else if (re_i) begin
                q_o <= mem_q[raddr_i];
            end
        end
    end else begin : g_fallback
        // No vendor macro mapped for other technologies yet: infer the same read port.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                q_o <= '0;
            end else if (re_i) begin
                q_o <= mem_q[raddr_i];
            end
        end
    end

endmodule

// File: rtl/rl_ram_fifo.sv
// First-word-fall-through FIFO built on rl_ram_1r1w.
// The head word is served either from a local output register (words pushed
// into an otherwise empty head slot bypass the RAM) or directly from the RAM
// read register. A RAM read is issued only when the head is popped and more
// words remain, so one push and one pop per cycle run without bubbles.
// Optional: define RL_RAM_FIFO_LEVEL_EN to add the count_o occupancy port.
module rl_ram_fifo
    import rl_ram_fifo_pkg::*;
#(
    parameter int unsigned ABITS      = 4,
    parameter int unsigned DBITS      = 32,
    parameter              TECHNOLOGY = "GENERIC"
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [DBITS-1:0] d_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [DBITS-1:0] q_o,
    input  logic             ready_i
`ifdef RL_RAM_FIFO_LEVEL_EN
    ,
    output logic [ABITS:0]   count_o
`endif
);

    localparam logic [ABITS:0]   CNT_ONE = (ABITS+1)'(1);
    localparam logic [ABITS-1:0] PTR_ONE = ABITS'(1);

    head_state_e      head_state_q, head_state_d;
    logic [ABITS-1:0] wptr_q, wptr_d;
    logic [ABITS-1:0] rptr_q, rptr_d;
    logic [ABITS:0]   count_q, count_d;
    logic             ready_q, ready_d;
    logic [DBITS-1:0] head_data_q, head_data_d;

    logic             push, pop, bypass;
    logic             ram_we, ram_re;
    logic [DBITS-1:0] ram_q;

    // Next-state: handshakes, bypass/RAM routing, pointers, occupancy.
    always_comb begin
        head_state_d = head_state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        head_data_d  = head_data_q;

        push = valid_i && ready_q;
        pop  = (head_state_q != EMPTY) && ready_i;

        // A push goes straight to the head register when the head slot is free
        // after this edge and the RAM holds nothing older.
        bypass = push && ((head_state_q == EMPTY) || (pop && (count_q == CNT_ONE)));
        ram_we = push && !bypass;
        // RAM holds count_q-1 words whenever a head exists; read only with one
        // stored. It never equals the write address: that would need an empty
        // or completely full RAM, and a full FIFO accepts no push.
        ram_re = pop && (count_q > CNT_ONE);

        if (ram_we) wptr_d = wptr_q + PTR_ONE;
        if (ram_re) rptr_d = rptr_q + PTR_ONE;

        if (bypass) begin
            head_data_d  = d_i;
            head_state_d = VALID;
        end else if (ram_re) begin
            head_state_d = LOADING;
        end else if (pop) begin
            head_state_d = EMPTY;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // count never exceeds DEPTH, so count < DEPTH is just a clear MSB.
        ready_d = !count_d[ABITS];
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_state_q <= EMPTY;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
        end else begin
            head_state_q <= head_state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
        end
    end

    // Bypass head data register; contents are don't-care unless the head is VALID.
    always_ff @(posedge clk_i) begin
        head_data_q <= head_data_d;
    end

    rl_ram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (DBITS),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .be_i    ('1),
        .d_i     (d_i),
        .re_i    (ram_re),
        .raddr_i (rptr_q),
        .q_o     (ram_q)
    );

    assign ready_o = ready_q;
    assign valid_o = (head_state_q != EMPTY);
    assign q_o     = (head_state_q == LOADING) ? ram_q : head_data_q;
`ifdef RL_RAM_FIFO_LEVEL_EN
    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_rl_ram_fifo.sv
// Self-checking bench for rl_ram_fifo (ABITS=2, DBITS=8, DEPTH=4).
// Define RL_RAM_FIFO_LEVEL_EN to also check count_o.
module tb_rl_ram_fifo;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [7:0] d_i;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] q_o;
    logic       ready_i;
`ifdef RL_RAM_FIFO_LEVEL_EN
    logic [2:0] count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rl_ram_fifo #(
        .ABITS      (2),
        .DBITS      (8),
        .TECHNOLOGY ("GENERIC")
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .d_i     (d_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .q_o     (q_o),
        .ready_i (ready_i)
`ifdef RL_RAM_FIFO_LEVEL_EN
        ,
        .count_o (count_o)
`endif
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       ri;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_q;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mq[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d, input logic ri,
                                input logic e_rdy, input logic e_vld, input logic [7:0] e_q, input int e_cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.ri = ri;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_q = e_q; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle against the queue model: drive, clock, then compare.
    task automatic model_cycle(input logic v, input logic [7:0] d, input logic ri, input string tag);
        logic do_push, do_pop;
        rst_i = 1'b0; valid_i = v; d_i = d; ready_i = ri;
        do_push = v && (mq.size() < 4);
        do_pop  = ri && (mq.size() > 0);
        step();
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        check({tag, " ready_o"}, 32'(ready_o), 32'(mq.size() < 4));
        check({tag, " valid_o"}, 32'(valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) check({tag, " q_o"}, 32'(q_o), 32'(mq[0]));
`ifdef RL_RAM_FIFO_LEVEL_EN
        check({tag, " count_o"}, 32'(count_o), 32'(mq.size()));
`endif
    endtask

    task automatic model_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        step();
        mq.delete();
        rst_i = 1'b0;
        check("model reset ready_o", 32'(ready_o), 32'd1);
        check("model reset valid_o", 32'(valid_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; d_i = '0; ready_i = 1'b0;

        // Reset, single push held under backpressure, then pop.
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 8'hA5, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hA5, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
        // Fill to full, fifth push dropped, drain in order.
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 1, 8'h01, 2));
        vecs.push_back(mk(0, 1, 8'h03, 0, 1, 1, 8'h01, 3));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0, 1, 8'h01, 4));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0, 1, 8'h01, 4));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h02, 3));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h03, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h04, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
        // Count=1 push+pop: new word next, count stays 1 (three more pushes fill).
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 1, 8'h11, 1));
        vecs.push_back(mk(0, 1, 8'h22, 1, 1, 1, 8'h22, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h22, 1));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 1, 8'h22, 2));
        vecs.push_back(mk(0, 1, 8'h44, 0, 1, 1, 8'h22, 3));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 1, 8'h22, 4));
        // Three stored, reset pulse, then a fresh word with no stale data.
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 3));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 1, 1, 8'h77, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i = vecs[i].rst; valid_i = vecs[i].v; d_i = vecs[i].d; ready_i = vecs[i].ri;
            step();
            check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) check($sformatf("vec%0d q_o", i), 32'(q_o), 32'(vecs[i].e_q));
`ifdef RL_RAM_FIFO_LEVEL_EN
            check($sformatf("vec%0d count_o", i), 32'(count_o), 32'(vecs[i].e_cnt));
`endif
        end

        // Streaming from empty: 0x10.. in order, valid every cycle after the first.
        for (int i = 0; i < 20; i++) begin
            rst_i = 1'b0; valid_i = 1'b1; d_i = 8'(8'h10 + i); ready_i = 1'b1;
            step();
            check($sformatf("stream%0d valid_o", i), 32'(valid_o), 32'd1);
            check($sformatf("stream%0d q_o", i), 32'(q_o), 32'(8'h10 + i));
        end
        valid_i = 1'b0;
        step();
        check("stream drain valid_o", 32'(valid_o), 32'd0);

        // Streaming with words held in the RAM (count 2 and 3) via the queue model.
        model_reset();
        model_cycle(1'b1, 8'hC0, 1'b0, "pre0");
        model_cycle(1'b1, 8'hC1, 1'b0, "pre1");
        for (int i = 0; i < 12; i++) model_cycle(1'b1, 8'(8'h40 + i), 1'b1, $sformatf("ram2_%0d", i));
        model_cycle(1'b1, 8'hC2, 1'b0, "pre2");
        for (int i = 0; i < 12; i++) model_cycle(1'b1, 8'(8'h60 + i), 1'b1, $sformatf("ram3_%0d", i));
        for (int i = 0; i < 4; i++) model_cycle(1'b0, 8'h00, 1'b1, $sformatf("drain%0d", i));

        // Random push/pop traffic against the queue model.
        for (int i = 0; i < 1000; i++) begin
            model_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                        $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
